regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two writeback ports (ALU, memory load), each
// buffered in a 2-entry FIFO, drained round-robin into a single write stage.
module regfile_write_arbiter #(
    parameter bit DROP_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [3:0]  m_reg,
    input  logic [15:0] m_data,
    output logic        WriteReg,
    output logic [3:0]  RegId,
    output logic [15:0] WriteData,
    output logic [15:0] pend_mask
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_M = 1'b1
    } port_e;

    logic [1:0][1:0][3:0]  fid_q, fid_d;
    logic [1:0][1:0][15:0] fdat_q, fdat_d;
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [1:0][1:0]       cnt_q, cnt_d;
    port_e                 last_q, last_d;
    logic                  write_q, write_d;
    logic [3:0]            id_q, id_d;
    logic [15:0]           dat_q, dat_d;

    logic [1:0]            in_valid, push, pop, nempty, full;
    logic [1:0][3:0]       in_id;
    logic [1:0][15:0]      in_dat;
    port_e                 win;
    logic                  grant;
    logic [3:0]            head_id;
    logic [15:0]           head_dat;
    logic [15:0]           pend;

    always_comb begin
        in_valid  = {m_valid, a_valid};
        in_id[0]  = a_reg;
        in_id[1]  = m_reg;
        in_dat[0] = a_data;
        in_dat[1] = m_data;
        for (int unsigned p = 0; p < 2; p++) begin
            full[p]   = (cnt_q[p] == 2'd2);
            nempty[p] = (cnt_q[p] != 2'd0);
            // Ready only reflects occupancy at the edge; a same-cycle pop does not free a slot.
            push[p]   = in_valid[p] & ~full[p];
        end

        grant = |nempty;
        if (nempty[0] && nempty[1])
            win = (last_q == PORT_A) ? PORT_M : PORT_A;
        else if (nempty[1])
            win = PORT_M;
        else
            win = PORT_A;
        pop = '0;
        if (grant)
            pop[win] = 1'b1;
        head_id  = fid_q[win][rptr_q[win]];
        head_dat = fdat_q[win][rptr_q[win]];

        fid_d  = fid_q;
        fdat_d = fdat_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int unsigned p = 0; p < 2; p++) begin
            if (push[p]) begin
                fid_d[p][wptr_q[p]]  = in_id[p];
                fdat_d[p][wptr_q[p]] = in_dat[p];
                wptr_d[p]            = ~wptr_q[p];
            end
            if (pop[p])
                rptr_d[p] = ~rptr_q[p];
            cnt_d[p] = cnt_q[p] + 2'(push[p]) - 2'(pop[p]);
        end

        write_d = 1'b0;
        id_d    = id_q;
        dat_d   = dat_q;
        last_d  = last_q;
        if (grant) begin
            id_d    = head_id;
            dat_d   = head_dat;
            write_d = !(DROP_R0 && head_id == 4'd0);
            last_d  = win;
        end

        pend = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (cnt_q[p] == 2'd2 || (cnt_q[p] == 2'd1 && rptr_q[p] == s[0]))
                    pend[fid_q[p][s]] = 1'b1;
            end
        end
        if (write_q)
            pend[id_q] = 1'b1;
        if (DROP_R0)
            pend[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fid_q   <= '0;
            fdat_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= PORT_M;
            write_q <= 1'b0;
            id_q    <= '0;
            dat_q   <= '0;
        end else begin
            fid_q   <= fid_d;
            fdat_q  <= fdat_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            write_q <= write_d;
            id_q    <= id_d;
            dat_q   <= dat_d;
        end
    end

    assign a_ready   = ~full[0] & rst_n;
    assign m_ready   = ~full[1] & rst_n;
    assign WriteReg  = write_q;
    assign RegId     = id_q;
    assign WriteData = dat_q;
    assign pend_mask = pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes expected
// writes; a negedge monitor pops and compares every WriteReg pulse.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, m_valid;
    logic [3:0]  a_reg, m_reg;
    logic [15:0] a_data, m_data;
    logic        a_ready, m_ready, WriteReg;
    logic [3:0]  RegId;
    logic [15:0] WriteData, pend_mask;
    logic        a_ready_k, m_ready_k, WriteReg_k;
    logic [3:0]  RegId_k;
    logic [15:0] WriteData_k, pend_mask_k;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  wr_cnt   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
        .WriteReg(WriteReg), .RegId(RegId), .WriteData(WriteData), .pend_mask(pend_mask)
    );

    regfile_write_arbiter #(.DROP_R0(1'b0)) dut_k (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready_k), .a_reg(a_reg), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready_k), .m_reg(m_reg), .m_data(m_data),
        .WriteReg(WriteReg_k), .RegId(RegId_k), .WriteData(WriteData_k), .pend_mask(pend_mask_k)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse of the default instance must match the queue head.
    always @(negedge clk) begin
        if (rst_n && WriteReg) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write got RegId=%0d WriteData=%h expected none", RegId, WriteData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_regid", 32'(RegId), 32'(e.id));
                chk("wr_data", 32'(WriteData), 32'(e.dat));
            end
        end
    end

    task automatic idle_inputs();
        a_valid = 1'b0; m_valid = 1'b0;
        a_reg = '0; m_reg = '0; a_data = '0; m_data = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_writereg", 32'(WriteReg), 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'd0);
        chk("rst_readies", 32'({a_ready, m_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit exp_ar[7] = '{1, 1, 1, 0, 1, 0, 1};
    bit exp_mr[7] = '{1, 1, 0, 1, 0, 1, 0};

    initial begin
        int na, nm, wr_before;
        logic ar, mr;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("init_writereg", 32'(WriteReg), 32'd0);
        chk("init_regid", 32'(RegId), 32'd0);
        chk("init_wdata", 32'(WriteData), 32'd0);
        chk("init_pend", 32'(pend_mask), 32'd0);
        chk("init_readies", 32'({a_ready, m_ready}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_readies", 32'({a_ready, m_ready}), 32'd3);

        // Single push: latency and pend_mask lifetime
        @(negedge clk);
        a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
        exp_q.push_back('{4'd3, 16'h1234});
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("lat_k_writereg", 32'(WriteReg), 32'd0);
        chk("lat_k_pend", 32'(pend_mask), 32'h0008);
        @(posedge clk); #1;
        chk("lat_k1_writereg", 32'(WriteReg), 32'd1);
        chk("lat_k1_pend", 32'(pend_mask), 32'h0008);
        @(posedge clk); #1;
        chk("lat_k2_writereg", 32'(WriteReg), 32'd0);
        chk("lat_k2_pend", 32'(pend_mask), 32'h0000);
        chk("lat_hold_regid", 32'(RegId), 32'd3);

        // Register 0 write: dropped by default instance, issued with DROP_R0=0
        @(negedge clk);
        a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("r0_pend_drop", 32'(pend_mask), 32'h0000);
        chk("r0_pend_keep", 32'(pend_mask_k), 32'h0001);
        @(posedge clk); #1;
        chk("r0_writereg_drop", 32'(WriteReg), 32'd0);
        chk("r0_regid_drop", 32'(RegId), 32'd0);
        chk("r0_wdata_drop", 32'(WriteData), 32'hFFFF);
        chk("r0_pend_drop2", 32'(pend_mask), 32'h0000);
        chk("r0_writereg_keep", 32'(WriteReg_k), 32'd1);
        chk("r0_regid_keep", 32'(RegId_k), 32'd0);
        chk("r0_wdata_keep", 32'(WriteData_k), 32'hFFFF);

        // Same register from both ports in the same cycle, from reset: ALU first
        reset_dut();
        @(negedge clk);
        a_valid = 1'b1; a_reg = 4'd5; a_data = 16'hAAAA;
        m_valid = 1'b1; m_reg = 4'd5; m_data = 16'h5555;
        exp_q.push_back('{4'd5, 16'hAAAA});
        exp_q.push_back('{4'd5, 16'h5555});
        @(posedge clk); #1;
        idle_inputs();
        chk("same_pend", 32'(pend_mask), 32'h0020);
        @(posedge clk); #1;
        chk("same_first", 32'(WriteData), 32'hAAAA);
        @(posedge clk); #1;
        chk("same_second", 32'(WriteData), 32'h5555);
        chk("same_second_we", 32'(WriteReg), 32'd1);
        @(posedge clk); #1;
        chk("same_idle_we", 32'(WriteReg), 32'd0);
        chk("same_hold_data", 32'(WriteData), 32'h5555);
        chk("same_hold_regid", 32'(RegId), 32'd5);

        // Both ports push every cycle: strict alternation, FIFOs fill, readies alternate
        reset_dut();
        na = 0; nm = 0;
        for (int i = 0; i < 5; i++) exp_q.push_back('{4'd1, 16'(16'h1000 + i)});
        for (int i = 0; i < 4; i++) exp_q.insert(2 * i + 1, '{4'd2, 16'(16'h2000 + i)});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_reg = 4'd1; a_data = 16'(16'h1000 + na);
            m_valid = 1'b1; m_reg = 4'd2; m_data = 16'(16'h2000 + nm);
            chk($sformatf("stream_a_ready_%0d", i), 32'(a_ready), 32'(exp_ar[i]));
            chk($sformatf("stream_m_ready_%0d", i), 32'(m_ready), 32'(exp_mr[i]));
            ar = a_ready; mr = m_ready;
            @(posedge clk);
            if (ar) na++;
            if (mr) nm++;
        end
        @(negedge clk);
        idle_inputs();
        chk("stream_a_accepted", 32'(na), 32'd5);
        chk("stream_m_accepted", 32'(nm), 32'd4);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("stream_idle_we", 32'(WriteReg), 32'd0);

        // Reset in the middle of traffic discards buffered entries
        reset_dut();
        @(negedge clk);
        a_valid = 1'b1; a_reg = 4'd7; a_data = 16'h7000;
        m_valid = 1'b1; m_reg = 4'd8; m_data = 16'h8000;
        exp_q.push_back('{4'd7, 16'h7000});
        @(negedge clk);
        a_data = 16'h7001; m_data = 16'h8001;
        @(posedge clk); #1;
        chk("mid_pend", 32'(pend_mask), 32'h0180);
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(WriteReg), 32'd0);
        chk("mid_rst_regid", 32'(RegId), 32'd0);
        chk("mid_rst_wdata", 32'(WriteData), 32'd0);
        chk("mid_rst_pend", 32'(pend_mask), 32'd0);
        chk("mid_rst_readies", 32'({a_ready, m_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_readies", 32'({a_ready, m_ready}), 32'd3);
        wr_before = wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_no_writes", 32'(wr_cnt - wr_before), 32'd0);
        chk("mid_pend_after", 32'(pend_mask), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
